// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM-stage stack/data memory unit.
package mem_stage_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_STORE = 3'd2,
      OP_PUSH  = 3'd3,
      OP_POP   = 3'd4,
      OP_PUSH2 = 3'd5,
      OP_POP2  = 3'd6
   } op_t;

   typedef enum logic [1:0] {
      EXC_NONE = 2'd0,
      EXC_OVF  = 2'd1,
      EXC_UNF  = 2'd2
   } exc_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PUSH2_LO = 2'd1,
      POP2_HI  = 2'd2
   } state_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with registered read; a write cycle does not update rdata.
module sp_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
   end

endmodule

// File: rtl/stack_mem_unit.sv
// Data memory plus full-descending stack with two-word PUSH2/POP2 for PC save/restore.
//   state    | meaning
//   IDLE     | accepting ops, busy=0
//   PUSH2_LO | writing low word of PUSH2, busy=1
//   POP2_HI  | reading high word of POP2, busy=1
module stack_mem_unit
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10,
   parameter int SP_W   = ADDR_W + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                op_valid,
   input  logic [2:0]          op,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [2*DATA_W-1:0] wdata_wide,
   output logic [DATA_W-1:0]   rdata,
   output logic                rd_valid,
   output logic [2*DATA_W-1:0] rdata_wide,
   output logic                rd_wide_valid,
   output logic                busy,
   output logic [SP_W-1:0]     sp,
   output logic                stack_exc,
   output logic [1:0]          exc_cause
);

   localparam logic [SP_W-1:0] SP_EMPTY = SP_W'(2**ADDR_W);
   localparam logic [SP_W-1:0] POP2_MAX = SP_EMPTY - SP_W'(2);

   state_t            state;
   logic [DATA_W-1:0] word_hold;
   logic              rd_pend, wide_pend;
   logic              accept, push_ok, pop_ok, push2_ok, pop2_ok;
   logic              ram_we_raw, ram_we;
   logic [ADDR_W-1:0] ram_addr, sp_top, sp_dec;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   assign accept   = op_valid && !busy && (state == IDLE);
   assign push_ok  = (sp != '0);
   assign pop_ok   = (sp != SP_EMPTY);
   assign push2_ok = (sp >= SP_W'(2));
   assign pop2_ok  = (sp <= POP2_MAX);
   assign sp_top   = sp[ADDR_W-1:0];
   assign sp_dec   = ADDR_W'(sp - SP_W'(1));

   always_comb begin
      ram_we_raw = 1'b0;
      ram_addr   = addr;
      ram_wdata  = wdata;
      if (state == PUSH2_LO) begin
         ram_we_raw = 1'b1;
         ram_addr   = sp_dec;
         ram_wdata  = word_hold;
      end else if (state == POP2_HI) begin
         ram_addr = sp_top;
      end else if (accept) begin
         case (op)
            OP_STORE: ram_we_raw = 1'b1;
            OP_PUSH: begin
               ram_we_raw = push_ok;
               ram_addr   = sp_dec;
            end
            OP_POP:  ram_addr = sp_top;
            OP_PUSH2: begin
               ram_we_raw = push2_ok;
               ram_addr   = sp_dec;
               ram_wdata  = wdata_wide[2*DATA_W-1:DATA_W];
            end
            OP_POP2: ram_addr = sp_top;
            default: ram_we_raw = 1'b0;
         endcase
      end
   end

   // An abandoned PUSH2 must not write its low word on the reset edge.
   assign ram_we = ram_we_raw && !reset;

   sp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         busy          <= 1'b0;
         sp            <= SP_EMPTY;
         rdata         <= '0;
         rd_valid      <= 1'b0;
         rdata_wide    <= '0;
         rd_wide_valid <= 1'b0;
         stack_exc     <= 1'b0;
         exc_cause     <= EXC_NONE;
         word_hold     <= '0;
         rd_pend       <= 1'b0;
         wide_pend     <= 1'b0;
      end else begin
         rd_valid      <= 1'b0;
         rd_wide_valid <= 1'b0;
         stack_exc     <= 1'b0;
         rd_pend       <= 1'b0;
         wide_pend     <= 1'b0;
         if (rd_pend) begin
            rdata    <= ram_rdata;
            rd_valid <= 1'b1;
         end
         if (wide_pend) begin
            rdata_wide    <= {ram_rdata, word_hold};
            rd_wide_valid <= 1'b1;
         end
         case (state)
            PUSH2_LO: begin
               sp    <= sp - SP_W'(1);
               state <= IDLE;
               busy  <= 1'b0;
            end
            POP2_HI: begin
               word_hold <= ram_rdata;
               wide_pend <= 1'b1;
               sp        <= sp + SP_W'(1);
               state     <= IDLE;
               busy      <= 1'b0;
            end
            default: begin
               if (accept) begin
                  case (op)
                     OP_LOAD: rd_pend <= 1'b1;
                     OP_PUSH: begin
                        if (push_ok) sp <= sp - SP_W'(1);
                        else begin
                           stack_exc <= 1'b1;
                           exc_cause <= EXC_OVF;
                        end
                     end
                     OP_POP: begin
                        if (pop_ok) begin
                           sp      <= sp + SP_W'(1);
                           rd_pend <= 1'b1;
                        end else begin
                           stack_exc <= 1'b1;
                           exc_cause <= EXC_UNF;
                        end
                     end
                     OP_PUSH2: begin
                        if (push2_ok) begin
                           sp        <= sp - SP_W'(1);
                           word_hold <= wdata_wide[DATA_W-1:0];
                           state     <= PUSH2_LO;
                           busy      <= 1'b1;
                        end else begin
                           stack_exc <= 1'b1;
                           exc_cause <= EXC_OVF;
                        end
                     end
                     OP_POP2: begin
                        if (pop2_ok) begin
                           sp    <= sp + SP_W'(1);
                           state <= POP2_HI;
                           busy  <= 1'b1;
                        end else begin
                           stack_exc <= 1'b1;
                           exc_cause <= EXC_UNF;
                        end
                     end
                     default: rd_pend <= 1'b0;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stack_mem_unit.sv
// Directed vector bench for stack_mem_unit: table of single ops plus hand-written corner sequences.
module tb_stack_mem_unit;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [2:0]  op;
   logic [9:0]  addr;
   logic [15:0] wdata;
   logic [31:0] wdata_wide;
   logic [15:0] rdata;
   logic        rd_valid;
   logic [31:0] rdata_wide;
   logic        rd_wide_valid;
   logic        busy;
   logic [10:0] sp;
   logic        stack_exc;
   logic [1:0]  exc_cause;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   stack_mem_unit dut (
      .clk           (clk),
      .reset         (reset),
      .op_valid      (op_valid),
      .op            (op),
      .addr          (addr),
      .wdata         (wdata),
      .wdata_wide    (wdata_wide),
      .rdata         (rdata),
      .rd_valid      (rd_valid),
      .rdata_wide    (rdata_wide),
      .rd_wide_valid (rd_wide_valid),
      .busy          (busy),
      .sp            (sp),
      .stack_exc     (stack_exc),
      .exc_cause     (exc_cause)
   );

   typedef struct {
      logic [2:0]  op;
      logic [9:0]  addr;
      logic [15:0] wdata;
      logic [31:0] wide;
      logic        exp_exc;
      logic [1:0]  exp_cause;
      logic        exp_busy;
      logic        exp_rdv;
      logic [15:0] exp_rdata;
      logic        exp_wide;
      logic [31:0] exp_wdata;
      logic [10:0] exp_sp;
   } vec_t;

   vec_t vt[21];

   function automatic vec_t mk(input logic [2:0] o, input logic [9:0] a, input logic [15:0] wd,
                               input logic [31:0] ww, input logic ex, input logic [1:0] ca,
                               input logic bz, input logic rv, input logic [15:0] rd,
                               input logic wv, input logic [31:0] wr, input logic [10:0] s);
      vec_t v;
      v.op = o; v.addr = a; v.wdata = wd; v.wide = ww;
      v.exp_exc = ex; v.exp_cause = ca; v.exp_busy = bz;
      v.exp_rdv = rv; v.exp_rdata = rd; v.exp_wide = wv; v.exp_wdata = wr; v.exp_sp = s;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input int idx);
      @(negedge clk);
      op_valid = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata; wdata_wide = v.wide;
      @(posedge clk); #1;
      op_valid = 1'b0; op = OP_NOP; wdata_wide = 32'h0;
      chk("stack_exc_T", idx, 32'(stack_exc), 32'(v.exp_exc));
      chk("exc_cause", idx, 32'(exc_cause), 32'(v.exp_cause));
      chk("busy_T", idx, 32'(busy), 32'(v.exp_busy));
      @(posedge clk); #1;
      chk("rd_valid", idx, 32'(rd_valid), 32'(v.exp_rdv));
      if (v.exp_rdv) chk("rdata", idx, 32'(rdata), 32'(v.exp_rdata));
      chk("sp", idx, 32'(sp), 32'(v.exp_sp));
      chk("busy_T1", idx, 32'(busy), 32'd0);
      chk("exc_pulse_end", idx, 32'(stack_exc), 32'd0);
      if (v.exp_wide) begin
         chk("rd_wide_valid_T1", idx, 32'(rd_wide_valid), 32'd0);
         @(posedge clk); #1;
         chk("rd_wide_valid", idx, 32'(rd_wide_valid), 32'd1);
         chk("rdata_wide", idx, rdata_wide, v.exp_wdata);
      end else begin
         chk("rd_wide_valid_none", idx, 32'(rd_wide_valid), 32'd0);
      end
      if (v.exp_rdv) begin
         @(posedge clk); #1;
         chk("rd_valid_pulse", idx, 32'(rd_valid), 32'd0);
      end
   endtask

   initial begin
      //          op        addr   wdata     wide          exc  cause     bz rv rdata     wv wide          sp
      vt[0]  = mk(OP_STORE, 10'd5, 16'hBEEF, 32'h0,        0, EXC_NONE, 0, 0, 16'h0,    0, 32'h0,        11'd1024);
      vt[1]  = mk(OP_LOAD,  10'd5, 16'h0,    32'h0,        0, EXC_NONE, 0, 1, 16'hBEEF, 0, 32'h0,        11'd1024);
      vt[2]  = mk(OP_STORE, 10'd7, 16'hA5A5, 32'h0,        0, EXC_NONE, 0, 0, 16'h0,    0, 32'h0,        11'd1024);
      vt[3]  = mk(OP_LOAD,  10'd7, 16'h0,    32'h0,        0, EXC_NONE, 0, 1, 16'hA5A5, 0, 32'h0,        11'd1024);
      vt[4]  = mk(OP_LOAD,  10'd5, 16'h0,    32'h0,        0, EXC_NONE, 0, 1, 16'hBEEF, 0, 32'h0,        11'd1024);
      vt[5]  = mk(OP_PUSH,  10'd0, 16'h1111, 32'h0,        0, EXC_NONE, 0, 0, 16'h0,    0, 32'h0,        11'd1023);
      vt[6]  = mk(OP_POP,   10'd0, 16'h0,    32'h0,        0, EXC_NONE, 0, 1, 16'h1111, 0, 32'h0,        11'd1024);
      vt[7]  = mk(OP_POP,   10'd0, 16'h0,    32'h0,        1, EXC_UNF,  0, 0, 16'h0,    0, 32'h0,        11'd1024);
      vt[8]  = mk(OP_PUSH2, 10'd0, 16'h0,    32'hDEADBEEF, 0, EXC_UNF,  1, 0, 16'h0,    0, 32'h0,        11'd1022);
      vt[9]  = mk(OP_LOAD,  10'd1023, 16'h0, 32'h0,        0, EXC_UNF,  0, 1, 16'hDEAD, 0, 32'h0,        11'd1022);
      vt[10] = mk(OP_LOAD,  10'd1022, 16'h0, 32'h0,        0, EXC_UNF,  0, 1, 16'hBEEF, 0, 32'h0,        11'd1022);
      vt[11] = mk(OP_POP2,  10'd0, 16'h0,    32'h0,        0, EXC_UNF,  1, 0, 16'h0,    1, 32'hDEADBEEF, 11'd1024);
      vt[12] = mk(OP_PUSH,  10'd0, 16'h2222, 32'h0,        0, EXC_UNF,  0, 0, 16'h0,    0, 32'h0,        11'd1023);
      vt[13] = mk(OP_POP2,  10'd0, 16'h0,    32'h0,        1, EXC_UNF,  0, 0, 16'h0,    0, 32'h0,        11'd1023);
      vt[14] = mk(OP_POP,   10'd0, 16'h0,    32'h0,        0, EXC_UNF,  0, 1, 16'h2222, 0, 32'h0,        11'd1024);
      vt[15] = mk(OP_NOP,   10'd5, 16'h5555, 32'h0,        0, EXC_UNF,  0, 0, 16'h0,    0, 32'h0,        11'd1024);
      vt[16] = mk(3'd7,     10'd5, 16'h6666, 32'h0,        0, EXC_UNF,  0, 0, 16'h0,    0, 32'h0,        11'd1024);
      vt[17] = mk(OP_PUSH2, 10'd0, 16'h0,    32'hCAFEF00D, 0, EXC_UNF,  1, 0, 16'h0,    0, 32'h0,        11'd1022);
      vt[18] = mk(OP_POP,   10'd0, 16'h0,    32'h0,        0, EXC_UNF,  0, 1, 16'hF00D, 0, 32'h0,        11'd1023);
      vt[19] = mk(OP_POP,   10'd0, 16'h0,    32'h0,        0, EXC_UNF,  0, 1, 16'hCAFE, 0, 32'h0,        11'd1024);
      vt[20] = mk(OP_LOAD,  10'd5, 16'h0,    32'h0,        0, EXC_UNF,  0, 1, 16'hBEEF, 0, 32'h0,        11'd1024);

      reset = 1'b1; op_valid = 1'b0; op = OP_NOP; addr = '0; wdata = '0; wdata_wide = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sp", 0, 32'(sp), 32'd1024);
      chk("rst_busy", 0, 32'(busy), 32'd0);
      chk("rst_rd_valid", 0, 32'(rd_valid), 32'd0);
      chk("rst_rd_wide_valid", 0, 32'(rd_wide_valid), 32'd0);
      chk("rst_stack_exc", 0, 32'(stack_exc), 32'd0);
      chk("rst_exc_cause", 0, 32'(exc_cause), 32'(EXC_NONE));
      chk("rst_rdata", 0, 32'(rdata), 32'd0);
      chk("rst_rdata_wide", 0, rdata_wide, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 21; i++) apply(vt[i], i);

      // Fill stack to sp=1 with back-to-back pushes; push i lands at address 1023-i.
      for (int i = 0; i < 1023; i++) begin
         @(negedge clk);
         op_valid = 1'b1; op = OP_PUSH; wdata = 16'(i);
      end
      @(negedge clk);
      op_valid = 1'b0; op = OP_NOP;
      chk("fill_sp", 100, 32'(sp), 32'd1);
      apply(mk(OP_PUSH2, 10'd0, 16'h0, 32'h12345678, 1, EXC_OVF, 0, 0, 16'h0, 0, 32'h0, 11'd1), 101);
      apply(mk(OP_PUSH, 10'd0, 16'h9999, 32'h0, 0, EXC_OVF, 0, 0, 16'h0, 0, 32'h0, 11'd0), 102);
      apply(mk(OP_PUSH, 10'd0, 16'h7777, 32'h0, 1, EXC_OVF, 0, 0, 16'h0, 0, 32'h0, 11'd0), 103);
      apply(mk(OP_POP, 10'd0, 16'h0, 32'h0, 0, EXC_OVF, 0, 1, 16'h9999, 0, 32'h0, 11'd1), 104);
      apply(mk(OP_POP, 10'd0, 16'h0, 32'h0, 0, EXC_OVF, 0, 1, 16'h03FE, 0, 32'h0, 11'd2), 105);

      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("rerst_sp", 200, 32'(sp), 32'd1024);
      chk("rerst_exc_cause", 200, 32'(exc_cause), 32'(EXC_NONE));

      // op_valid held high through the PUSH2 busy cycle must not issue a second op.
      @(negedge clk);
      op_valid = 1'b1; op = OP_PUSH2; wdata_wide = 32'h13572468;
      @(posedge clk); #1;
      chk("hold_busy", 201, 32'(busy), 32'd1);
      op = OP_PUSH; wdata = 16'h7777; wdata_wide = 32'h0;
      @(posedge clk); #1;
      op_valid = 1'b0; op = OP_NOP;
      chk("hold_sp_T1", 201, 32'(sp), 32'd1022);
      chk("hold_busy_T1", 201, 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("hold_sp_T2", 201, 32'(sp), 32'd1022);
      apply(mk(OP_POP, 10'd0, 16'h0, 32'h0, 0, EXC_NONE, 0, 1, 16'h2468, 0, 32'h0, 11'd1023), 202);
      apply(mk(OP_POP, 10'd0, 16'h0, 32'h0, 0, EXC_NONE, 0, 1, 16'h1357, 0, 32'h0, 11'd1024), 203);

      // Reset while in PUSH2_LO.
      @(negedge clk);
      op_valid = 1'b1; op = OP_PUSH2; wdata_wide = 32'hABCD0123;
      @(posedge clk); #1;
      op_valid = 1'b0; op = OP_NOP;
      chk("mid_busy", 300, 32'(busy), 32'd1);
      chk("mid_sp", 300, 32'(sp), 32'd1023);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_busy", 300, 32'(busy), 32'd0);
      chk("mid_rst_sp", 300, 32'(sp), 32'd1024);
      @(negedge clk); reset = 1'b0;
      apply(mk(OP_LOAD, 10'd1023, 16'h0, 32'h0, 0, EXC_NONE, 0, 1, 16'hABCD, 0, 32'h0, 11'd1024), 301);
      apply(mk(OP_LOAD, 10'd1022, 16'h0, 32'h0, 0, EXC_NONE, 0, 1, 16'h2468, 0, 32'h0, 11'd1024), 302);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
